bfly_stage_ctrl: RTL and testbench



---
 rtl/bfly_stage_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bfly_stage_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: counts beats, steers the delay line and butterfly.
// Optional protocol checking is enabled by defining BFLY_STAGE_CTRL_ERR_EN.
module bfly_stage_ctrl #(
    parameter int NUM    = 16,
    parameter int DATA   = 512,
    parameter int COUNT  = DATA / NUM,
    parameter int HALF   = COUNT / 2,
    parameter int BF_LAT = 1,
    localparam int TW_W  = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    output logic            in_ready,
    input  logic            flush_req,
    output logic            sr_write,
    output logic            sr_src,
    output logic            sr_read,
    output logic            bfly_en,
    output logic [TW_W-1:0] tw_idx,
    output logic            out_sel,
    output logic            valid_out,
    output logic            frame_done,
    output logic            busy,
    output logic            err
);

    typedef enum logic [2:0] {IDLE, FILL, CALC, PEND, FLUSH} state_t;

    localparam logic [TW_W-1:0] LAST_BEAT = TW_W'(HALF - 1);

    state_t            state_q, state_d;
    logic [TW_W-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [BF_LAT-1:0] vld_q, vld_d;
    logic [BF_LAT-1:0] sel_q, sel_d;
    logic [BF_LAT-1:0] done_q, done_d;

    logic accept;
    logic last_beat;
    logic iss_vld, iss_sel, iss_last;

    assign in_ready  = (state_q != FLUSH);
    // Gating with rst keeps the issue strobes quiet while reset is held.
    assign accept    = valid_in && in_ready && !rst;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE, FILL, PEND: begin
                // PEND/IDLE beats are FILL beat 0 (cnt_q is already 0 there).
                if (accept) begin
                    cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = CALC;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end else if (state_q == PEND && flush_req) begin
                    state_d = FLUSH;
                end
            end
            CALC: begin
                if (accept) begin
                    cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = PEND;
                        pend_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                if (last_beat) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_write = 1'b0;
        sr_src   = 1'b0;
        sr_read  = 1'b0;
        bfly_en  = 1'b0;
        tw_idx   = '0;
        iss_vld  = 1'b0;
        iss_sel  = 1'b0;
        iss_last = 1'b0;
        unique case (state_q)
            IDLE, FILL, PEND: begin
                if (accept) begin
                    sr_write = 1'b1;
                    if (pend_q) begin
                        sr_read  = 1'b1;
                        iss_vld  = 1'b1;
                        iss_sel  = 1'b1;
                        iss_last = last_beat;
                    end
                end
            end
            CALC: begin
                tw_idx = cnt_q;
                if (accept) begin
                    sr_read  = 1'b1;
                    bfly_en  = 1'b1;
                    sr_write = 1'b1;
                    sr_src   = 1'b1;
                    iss_vld  = 1'b1;
                end
            end
            FLUSH: begin
                sr_read  = 1'b1;
                sr_write = 1'b1;
                iss_vld  = 1'b1;
                iss_sel  = 1'b1;
                iss_last = last_beat;
            end
            default: ;
        endcase
    end

    // Output-side flags follow the butterfly latency.
    always_comb begin
        vld_d     = vld_q;
        sel_d     = sel_q;
        done_d    = done_q;
        vld_d[0]  = iss_vld;
        sel_d[0]  = iss_vld && iss_sel;
        done_d[0] = iss_vld && iss_last;
        for (int i = 1; i < BF_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            sel_d[i]  = sel_q[i-1];
            done_d[i] = done_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            sel_q  <= '0;
            done_q <= '0;
        end else begin
            vld_q  <= vld_d;
            sel_q  <= sel_d;
            done_q <= done_d;
        end
    end

    assign valid_out  = vld_q[BF_LAT-1];
    assign out_sel    = sel_q[BF_LAT-1];
    assign frame_done = done_q[BF_LAT-1];

`ifdef BFLY_STAGE_CTRL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (valid_in && !in_ready)
              | (flush_req && (state_q == FILL || state_q == CALC));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Directed bench for bfly_stage_ctrl: frame-position model feeds an output scoreboard.
module tb_bfly_stage_ctrl;

    localparam int NUM    = 16;
    localparam int DATA   = 512;
    localparam int COUNT  = DATA / NUM;
    localparam int HALF   = COUNT / 2;
    localparam int BF_LAT = 1;
    localparam int TW_W   = $clog2(HALF);
`ifdef BFLY_STAGE_CTRL_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic            in_ready;
    logic            flush_req;
    logic            sr_write, sr_src, sr_read, bfly_en;
    logic [TW_W-1:0] tw_idx;
    logic            out_sel, valid_out, frame_done, busy, err;

    bfly_stage_ctrl #(.NUM(NUM), .DATA(DATA), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
        .flush_req(flush_req), .sr_write(sr_write), .sr_src(sr_src),
        .sr_read(sr_read), .bfly_en(bfly_en), .tw_idx(tw_idx),
        .out_sel(out_sel), .valid_out(valid_out), .frame_done(frame_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sel;
        logic last;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   vo_cnt = 0;
    int   fd_cnt = 0;

    // Model state: position within the input frame, pending second half, flush countdown.
    int   m_pos  = 0;
    logic m_pend = 1'b0;
    int   m_fl   = 0;
    logic m_err  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (valid_out) begin
            vo_cnt++;
            if (frame_done) fd_cnt++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $error("FAIL out_unexpected: got sel=%0b done=%0b at cyc %0d, required no output",
                       out_sel, frame_done, cyc);
            end else begin
                e = q.pop_front();
                assert (out_sel === e.sel && frame_done === e.last && cyc == e.cyc) else begin
                    errors++;
                    $error("FAIL out_beat: got sel=%0b done=%0b cyc=%0d, required sel=%0b done=%0b cyc=%0d",
                           out_sel, frame_done, cyc, e.sel, e.last, e.cyc);
                end
            end
        end else begin
            checks++;
            assert ({out_sel, frame_done} === 2'b00) else begin
                errors++;
                $error("FAIL out_idle: got sel=%0b done=%0b with valid_out=0, required 00",
                       out_sel, frame_done);
            end
        end
    end

    task automatic cyc_step(input logic v, input logic f);
        logic [TW_W+5:0] exp_v, obs_v;
        logic            e_rdy, e_busy, e_wr, e_src, e_rd, e_bf, e_iss, e_sel, e_last;
        logic [TW_W-1:0] e_tw;
        valid_in  = v;
        flush_req = f;
        @(negedge clk);
        e_rdy  = (m_fl == 0);
        e_busy = (m_fl != 0) || (m_pos != 0) || m_pend;
        e_wr = 0; e_src = 0; e_rd = 0; e_bf = 0; e_tw = '0;
        e_iss = 0; e_sel = 0; e_last = 0;
        if (m_fl != 0) begin
            e_wr = 1; e_rd = 1; e_iss = 1; e_sel = 1; e_last = (m_fl == 1);
        end else if (v) begin
            if (m_pos < HALF) begin
                e_wr = 1; e_rd = m_pend;
                e_iss = m_pend; e_sel = 1; e_last = (m_pos == HALF - 1);
            end else begin
                e_wr = 1; e_src = 1; e_rd = 1; e_bf = 1; e_tw = TW_W'(m_pos - HALF);
                e_iss = 1; e_sel = 0;
            end
        end else if (m_pos >= HALF) begin
            e_tw = TW_W'(m_pos - HALF);
        end
        exp_v = {e_rdy, e_busy, e_wr, e_src, e_rd, e_bf, e_tw};
        obs_v = {in_ready, busy, sr_write, sr_src, sr_read, bfly_en, tw_idx};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL strobes (rdy,busy,wr,src,rd,bf,tw) at pos %0d: got %b, required %b",
                   m_pos, obs_v, exp_v);
        end
        checks++;
        assert (err === m_err) else begin
            errors++;
            $error("FAIL err: got %b, required %b", err, m_err);
        end
        if (e_iss) q.push_back('{e_sel, e_last, cyc + BF_LAT});
        if (m_fl != 0) begin
            if (v) m_err = ERR_EN;
            m_fl--;
        end else if (v) begin
            if (m_pos == HALF - 1) m_pend = 0;
            if (m_pos == COUNT - 1) m_pend = 1;
            m_pos = (m_pos + 1) % COUNT;
        end else if (f && m_pos == 0 && m_pend) begin
            m_fl   = HALF;
            m_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [TW_W+9:0] obs_v, exp_v;
        valid_in  = 0;
        flush_req = 0;
        rst       = 1;
        #1;
        q.delete();
        m_pos = 0; m_pend = 0; m_fl = 0; m_err = 0;
        obs_v = {valid_out, out_sel, frame_done, busy, err, in_ready,
                 sr_write, sr_src, sr_read, bfly_en, tw_idx};
        exp_v = {6'b000001, 4'b0000, {TW_W{1'b0}}};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL reset_vals (vo,sel,fd,busy,err,rdy,wr,src,rd,bf,tw): got %b, required %b",
                   obs_v, exp_v);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic check_int(input string tag, input int got, input int req);
        checks++;
        assert (got == req) else begin
            errors++;
            $error("FAIL %s: got %0d, required %0d", tag, got, req);
        end
    endtask

    initial begin
        rst       = 1;
        valid_in  = 0;
        flush_req = 0;
        do_reset();
        repeat (2) cyc_step(0, 0);

        // Single frame followed by a flush, then idle.
        repeat (COUNT) cyc_step(1, 0);
        cyc_step(0, 1);
        repeat (HALF) cyc_step(0, 0);
        repeat (2) cyc_step(0, 0);

        // Three frames back to back; the third frame's second half waits for the flush.
        vo_cnt = 0;
        fd_cnt = 0;
        repeat (3 * COUNT) cyc_step(1, 0);
        cyc_step(0, 0);
        check_int("b2b_valid_out", vo_cnt, 5 * HALF);
        check_int("b2b_frame_done", fd_cnt, 2);
        cyc_step(0, 1);
        repeat (HALF) cyc_step(0, 0);
        cyc_step(0, 0);
        check_int("b2b_flush_valid_out", vo_cnt, 6 * HALF);
        check_int("b2b_flush_frame_done", fd_cnt, 3);

        // Reset in the middle of CALC, then a fresh frame.
        repeat (HALF + 10) cyc_step(1, 0);
        do_reset();
        repeat (COUNT) cyc_step(1, 0);
        cyc_step(0, 1);
        repeat (HALF) cyc_step(0, 0);

        // Stall at CALC beat 7, then a beat offered during FLUSH.
        repeat (HALF + 7) cyc_step(1, 0);
        repeat (3) cyc_step(0, 0);
        repeat (HALF - 7) cyc_step(1, 0);
        cyc_step(0, 1);
        cyc_step(0, 0);
        cyc_step(1, 0);
        repeat (HALF - 2) cyc_step(0, 0);

        // Following frame: err must remain as set (or stay 0 without checking).
        repeat (COUNT) cyc_step(1, 0);
        cyc_step(0, 1);
        repeat (HALF) cyc_step(0, 0);
        repeat (2) cyc_step(0, 0);
        check_int("scoreboard_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
